// File: rtl/mem_access_stage_pkg.sv
// Shared MEM-stage definitions: load/store op codes, constants, FSM encoding and op classifiers.
// Pure declarations; no timing or flow control of its own.
package mem_access_stage_pkg;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;

    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic [4:0]  NOP_REG_ADDR = 5'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_load(input logic [7:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Address bits below the access size that must be zero for a naturally aligned access.
    function automatic logic misaligned(input logic [7:0] op, input logic [1:0] lo);
        if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH))
            return lo[0];
        if ((op == OP_LW) || (op == OP_SW))
            return lo != 2'b00;
        return 1'b0;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-bus bundle between the MEM stage (master) and memory (slave).
// req is held until a one-cycle ack; err pulses when the master gives up waiting.
interface mem_access_stage_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_sel, bus_wdata, bus_err,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata, bus_err,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering: store enables/data and sign/zero-extended load data.
// Purely combinational, zero latency, no flow control.
module mem_lane_align
    import mem_access_stage_pkg::*;
(
    input  logic [7:0]  aluop,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] reg2,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        case (addr_lo)
            2'b00:   rbyte = rdata[31:24];
            2'b01:   rbyte = rdata[23:16];
            2'b10:   rbyte = rdata[15:8];
            default: rbyte = rdata[7:0];
        endcase
        rhalf = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    end

    always_comb begin
        sel       = 4'b0000;
        wdata     = ZERO_WORD;
        load_data = ZERO_WORD;
        case (aluop)
            OP_LB: begin
                sel       = 4'b1000 >> addr_lo;
                load_data = {{24{rbyte[7]}}, rbyte};
            end
            OP_LBU: begin
                sel       = 4'b1000 >> addr_lo;
                load_data = {24'h0, rbyte};
            end
            OP_LH: begin
                sel       = addr_lo[1] ? 4'b0011 : 4'b1100;
                load_data = {{16{rhalf[15]}}, rhalf};
            end
            OP_LHU: begin
                sel       = addr_lo[1] ? 4'b0011 : 4'b1100;
                load_data = {16'h0, rhalf};
            end
            OP_LW: begin
                sel       = 4'b1111;
                load_data = rdata;
            end
            OP_SB: begin
                sel   = 4'b1000 >> addr_lo;
                wdata = {4{reg2[7:0]}};
            end
            OP_SH: begin
                sel   = addr_lo[1] ? 4'b0011 : 4'b1100;
                wdata = {2{reg2[15:0]}};
            end
            OP_SW: begin
                sel   = 4'b1111;
                wdata = reg2;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: loads/stores over a req/ack bus, 3+k cycles per memory op, stalls upstream until done.
// Non-memory ops pass through combinationally. MEM_ALIGN_CHECK_EN enables misalignment exceptions.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [31:0]                mem_wdata_i,
    input  logic [4:0]                 mem_wd_i,
    input  logic                       mem_wreg_i,
    input  logic [7:0]                 mem_aluop_i,
    input  logic [31:0]                mem_mem_addr_i,
    input  logic [31:0]                mem_reg2_i,
    output logic                       stall_req,
    mem_access_stage_if.master         bus,
    output logic [31:0]                wb_wdata,
    output logic [4:0]                 wb_wd,
    output logic                       wb_wreg,
    output logic                       align_exc
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    logic [31:0]   rdata_q;
    logic [CW-1:0] cnt;

    logic          op_load;
    logic          op_store;
    logic          misalign;
    logic          start;
    logic [3:0]    lane_sel;
    logic [31:0]   lane_wdata;
    logic [31:0]   load_data;

    assign op_load  = is_load(mem_aluop_i);
    assign op_store = is_store(mem_aluop_i);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = (op_load || op_store) && misaligned(mem_aluop_i, mem_mem_addr_i[1:0]);
`else
    assign misalign = 1'b0;
`endif

    assign start     = (state == ST_IDLE) && (op_load || op_store) && !misalign;
    assign align_exc = !rst && (state == ST_IDLE) && misalign;

    mem_lane_align u_lane (
        .aluop     (mem_aluop_i),
        .addr_lo   (mem_mem_addr_i[1:0]),
        .reg2      (mem_reg2_i),
        .rdata     (rdata_q),
        .sel       (lane_sel),
        .wdata     (lane_wdata),
        .load_data (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_sel   <= 4'b0000;
            bus.bus_addr  <= ZERO_WORD;
            bus.bus_wdata <= ZERO_WORD;
            bus.bus_err   <= 1'b0;
            rdata_q       <= ZERO_WORD;
            cnt           <= '0;
        end else begin
            bus.bus_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bus.bus_addr  <= {mem_mem_addr_i[31:2], 2'b00};
                        bus.bus_sel   <= lane_sel;
                        bus.bus_wdata <= lane_wdata;
                        bus.bus_we    <= op_store;
                        bus.bus_req   <= 1'b1;
                        cnt           <= '0;
                        state         <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (bus.bus_ack) begin
                        rdata_q     <= bus.bus_rdata;
                        bus.bus_req <= 1'b0;
                        state       <= ST_DONE;
                    end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
                        // Abandoned access: loads write back zero rather than stale data.
                        rdata_q     <= ZERO_WORD;
                        bus.bus_req <= 1'b0;
                        bus.bus_err <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        stall_req = 1'b0;
        wb_wdata  = mem_wdata_i;
        wb_wd     = mem_wd_i;
        wb_wreg   = mem_wreg_i;
        if (rst) begin
            wb_wdata = ZERO_WORD;
            wb_wd    = NOP_REG_ADDR;
            wb_wreg  = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        stall_req = 1'b1;
                        wb_wdata  = ZERO_WORD;
                        wb_wd     = NOP_REG_ADDR;
                        wb_wreg   = 1'b0;
                    end else if (misalign) begin
                        wb_wreg = 1'b0;
                    end
                end
                ST_BUSY: begin
                    stall_req = 1'b1;
                    wb_wdata  = ZERO_WORD;
                    wb_wd     = NOP_REG_ADDR;
                    wb_wreg   = 1'b0;
                end
                ST_DONE: begin
                    if (op_load)
                        wb_wdata = load_data;
                    else if (op_store)
                        wb_wreg = 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboarded bench for mem_access_stage: directed ops, bus responder, writeback monitor.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_wdata_i, mem_mem_addr_i, mem_reg2_i;
    logic [4:0]  mem_wd_i;
    logic        mem_wreg_i;
    logic [7:0]  mem_aluop_i;
    logic        stall_req, wb_wreg, align_exc;
    logic [31:0] wb_wdata;
    logic [4:0]  wb_wd;

    mem_access_stage_if mbus();

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_wdata_i    (mem_wdata_i),
        .mem_wd_i       (mem_wd_i),
        .mem_wreg_i     (mem_wreg_i),
        .mem_aluop_i    (mem_aluop_i),
        .mem_mem_addr_i (mem_mem_addr_i),
        .mem_reg2_i     (mem_reg2_i),
        .stall_req      (stall_req),
        .bus            (mbus),
        .wb_wdata       (wb_wdata),
        .wb_wd          (wb_wd),
        .wb_wreg        (wb_wreg),
        .align_exc      (align_exc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] wdata;
        logic        wchk;
    } bus_exp_t;

    typedef struct {
        int          dly;
        logic [31:0] rdata;
        logic        ack;
    } resp_t;

    typedef struct {
        logic [31:0] wdata;
        logic        dchk;
        logic [4:0]  wd;
        logic        wreg;
        logic        err;
        logic        aexc;
        int          stalls;
    } wb_exp_t;

    bus_exp_t bus_q[$];
    resp_t    resp_q[$];
    wb_exp_t  wb_q[$];

    int   n_vec = 0;
    int   n_mis = 0;
    int   n_req = 0;
    int   n_errp = 0;
    int   stall_cnt = 0;
    logic drv_act = 1'b0;
    logic wb_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_bus(input logic [31:0] a, input logic [3:0] s, input logic we,
                            input logic [31:0] wd, input logic wchk);
        bus_exp_t b;
        b.addr = a; b.sel = s; b.we = we; b.wdata = wd; b.wchk = wchk;
        bus_q.push_back(b);
    endtask

    task automatic push_resp(input int dly, input logic [31:0] rd, input logic ack);
        resp_t r;
        r.dly = dly; r.rdata = rd; r.ack = ack;
        resp_q.push_back(r);
    endtask

    task automatic push_wb(input logic [31:0] wdata, input logic dchk, input logic [4:0] wd,
                           input logic wreg, input logic err, input logic aexc, input int stalls);
        wb_exp_t e;
        e.wdata = wdata; e.dchk = dchk; e.wd = wd; e.wreg = wreg;
        e.err = err; e.aexc = aexc; e.stalls = stalls;
        wb_q.push_back(e);
    endtask

    task automatic set_nop();
        mem_aluop_i    = OP_NOP;
        mem_mem_addr_i = 32'h0;
        mem_reg2_i     = 32'h0;
        mem_wdata_i    = 32'h0;
        mem_wd_i       = 5'd0;
        mem_wreg_i     = 1'b0;
    endtask

    // Called just after a rising edge; holds the op until the monitor has seen its writeback cycle.
    task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                          input logic [31:0] alu, input logic [4:0] wd, input logic wreg);
        int n;
        mem_aluop_i = op; mem_mem_addr_i = addr; mem_reg2_i = reg2;
        mem_wdata_i = alu; mem_wd_i = wd; mem_wreg_i = wreg;
        wb_seen = 1'b0;
        drv_act = 1'b1;
        n = 0;
        while (!wb_seen && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!wb_seen) begin
            n_vec++; n_mis++;
            $display("FAIL op_timeout: op 0x%02h got no writeback cycle, want one within 40 cycles", op);
        end
        drv_act = 1'b0;
        set_nop();
    endtask

    // Bus responder: checks each new request, then acks after the scripted delay.
    initial begin
        bus_exp_t b;
        resp_t    r;
        mbus.bus_ack   = 1'b0;
        mbus.bus_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mbus.bus_req === 1'b1) begin
                n_req++;
                if (bus_q.size() == 0) begin
                    n_vec++; n_mis++;
                    $display("FAIL bus_unexpected: got request addr 0x%08h, want none", mbus.bus_addr);
                end else begin
                    b = bus_q.pop_front();
                    chk("bus_addr", mbus.bus_addr, b.addr);
                    chk("bus_sel", {28'h0, mbus.bus_sel}, {28'h0, b.sel});
                    chk("bus_we", {31'h0, mbus.bus_we}, {31'h0, b.we});
                    if (b.wchk) chk("bus_wdata", mbus.bus_wdata, b.wdata);
                end
                if (resp_q.size() != 0) r = resp_q.pop_front();
                else begin r.dly = 0; r.rdata = 32'h0; r.ack = 1'b0; end
                if (r.ack) begin
                    repeat (r.dly) @(negedge clk);
                    mbus.bus_rdata = r.rdata;
                    mbus.bus_ack   = 1'b1;
                    @(negedge clk);
                    mbus.bus_ack   = 1'b0;
                    mbus.bus_rdata = 32'h0;
                end else begin
                    for (int i = 0; i < 40 && mbus.bus_req === 1'b1; i++) @(negedge clk);
                end
            end
        end
    end

    // Writeback monitor: the first non-stalled cycle of an active op is its writeback cycle.
    initial begin
        wb_exp_t e;
        forever begin
            @(negedge clk);
            if (mbus.bus_err === 1'b1) n_errp++;
            if (!rst && drv_act) begin
                if (stall_req) begin
                    stall_cnt++;
                end else begin
                    if (wb_q.size() == 0) begin
                        n_vec++; n_mis++;
                        $display("FAIL wb_unexpected: got writeback wd %0d, want none", wb_wd);
                    end else begin
                        e = wb_q.pop_front();
                        if (e.dchk) chk("wb_wdata", wb_wdata, e.wdata);
                        chk("wb_wd", {27'h0, wb_wd}, {27'h0, e.wd});
                        chk("wb_wreg", {31'h0, wb_wreg}, {31'h0, e.wreg});
                        chk("bus_err", {31'h0, mbus.bus_err}, {31'h0, e.err});
                        chk("align_exc", {31'h0, align_exc}, {31'h0, e.aexc});
                        chk("stall_cycles", stall_cnt, e.stalls);
                    end
                    stall_cnt = 0;
                    wb_seen   = 1'b1;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, want finish before 100us");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        mem_aluop_i = OP_LW; mem_mem_addr_i = 32'h104; mem_reg2_i = 32'h0;
        mem_wdata_i = 32'h1111_1111; mem_wd_i = 5'd5; mem_wreg_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {31'h0, stall_req}, 32'h0);
        chk("rst_wb_wreg", {31'h0, wb_wreg}, 32'h0);
        chk("rst_wb_wd", {27'h0, wb_wd}, 32'h0);
        chk("rst_wb_wdata", wb_wdata, 32'h0);
        chk("rst_bus_req", {31'h0, mbus.bus_req}, 32'h0);
        chk("rst_bus_addr", mbus.bus_addr, 32'h0);
        chk("rst_bus_sel", {28'h0, mbus.bus_sel}, 32'h0);
        chk("rst_bus_err", {31'h0, mbus.bus_err}, 32'h0);
        chk("rst_align_exc", {31'h0, align_exc}, 32'h0);
        set_nop();
        rst = 1'b0;
        @(posedge clk); #1;

        // SW, ack in the 3rd BUSY cycle: 4 stalled cycles, no register write.
        push_bus(32'h100, 4'b1111, 1'b1, 32'hDEAD_BEEF, 1'b1);
        push_resp(2, 32'h0, 1'b1);
        push_wb(32'h0, 1'b0, 5'd4, 1'b0, 1'b0, 1'b0, 4);
        run_op(OP_SW, 32'h100, 32'hDEAD_BEEF, 32'h100, 5'd4, 1'b1);

        push_bus(32'h200, 4'b0001, 1'b0, 32'h0, 1'b0);
        push_resp(0, 32'h1122_33F0, 1'b1);
        push_wb(32'hFFFF_FFF0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 2);
        run_op(OP_LB, 32'h203, 32'h0, 32'h203, 5'd8, 1'b1);

        push_bus(32'h200, 4'b0011, 1'b0, 32'h0, 1'b0);
        push_resp(1, 32'hAAAA_8001, 1'b1);
        push_wb(32'h0000_8001, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 3);
        run_op(OP_LHU, 32'h202, 32'h0, 32'h202, 5'd9, 1'b1);

        push_bus(32'h200, 4'b0011, 1'b0, 32'h0, 1'b0);
        push_resp(0, 32'hAAAA_8001, 1'b1);
        push_wb(32'hFFFF_8001, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 2);
        run_op(OP_LH, 32'h202, 32'h0, 32'h202, 5'd10, 1'b1);

        push_bus(32'h100, 4'b0100, 1'b1, 32'hA5A5_A5A5, 1'b1);
        push_resp(0, 32'h0, 1'b1);
        push_wb(32'h0, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 2);
        run_op(OP_SB, 32'h101, 32'h1234_56A5, 32'h101, 5'd2, 1'b0);

        push_bus(32'h100, 4'b0011, 1'b1, 32'hBEEF_BEEF, 1'b1);
        push_resp(1, 32'h0, 1'b1);
        push_wb(32'h0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 3);
        run_op(OP_SH, 32'h102, 32'h1234_BEEF, 32'h102, 5'd3, 1'b0);

        push_wb(32'h1234_5678, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 0);
        run_op(8'h21, 32'h103, 32'h5555_5555, 32'h1234_5678, 5'd7, 1'b1);

        // Stray ack while idle must not start or disturb anything.
        mbus.bus_ack = 1'b1; mbus.bus_rdata = 32'h7777_7777;
        @(posedge clk); #1;
        mbus.bus_ack = 1'b0; mbus.bus_rdata = 32'h0;
        chk("idle_ack_req", {31'h0, mbus.bus_req}, 32'h0);
        chk("idle_ack_stall", {31'h0, stall_req}, 32'h0);

        push_bus(32'h100, 4'b1000, 1'b0, 32'h0, 1'b0);
        push_resp(0, 32'h80FF_0000, 1'b1);
        push_wb(32'h0000_0080, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 2);
        run_op(OP_LBU, 32'h100, 32'h0, 32'h100, 5'd11, 1'b1);

        // Never acked: aborted after 4 BUSY cycles, writes back zero.
        push_bus(32'h400, 4'b1111, 1'b0, 32'h0, 1'b0);
        push_resp(0, 32'h0, 1'b0);
        push_wb(32'h0, 1'b1, 5'd12, 1'b1, 1'b1, 1'b0, 5);
        run_op(OP_LW, 32'h400, 32'h0, 32'h400, 5'd12, 1'b1);

`ifdef MEM_ALIGN_CHECK_EN
        push_wb(32'h0, 1'b0, 5'd13, 1'b0, 1'b0, 1'b1, 0);
        run_op(OP_LW, 32'h102, 32'h0, 32'h102, 5'd13, 1'b1);
        push_wb(32'h0, 1'b0, 5'd15, 1'b0, 1'b0, 1'b1, 0);
        run_op(OP_SH, 32'h101, 32'h0000_C0DE, 32'h101, 5'd15, 1'b0);
`else
        push_bus(32'h100, 4'b1111, 1'b0, 32'h0, 1'b0);
        push_resp(0, 32'hCAFE_F00D, 1'b1);
        push_wb(32'hCAFE_F00D, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 2);
        run_op(OP_LW, 32'h102, 32'h0, 32'h102, 5'd13, 1'b1);
        push_bus(32'h100, 4'b1100, 1'b1, 32'hC0DE_C0DE, 1'b1);
        push_resp(0, 32'h0, 1'b1);
        push_wb(32'h0, 1'b0, 5'd15, 1'b0, 1'b0, 1'b0, 2);
        run_op(OP_SH, 32'h101, 32'h0000_C0DE, 32'h101, 5'd15, 1'b0);
`endif

        // Reset in mid-BUSY, then a late ack that must be ignored.
        push_bus(32'h300, 4'b1111, 1'b0, 32'h0, 1'b0);
        push_resp(0, 32'h0, 1'b0);
        mem_aluop_i = OP_LW; mem_mem_addr_i = 32'h300; mem_wd_i = 5'd3; mem_wreg_i = 1'b1;
        @(posedge clk); #1;
        chk("busy_req", {31'h0, mbus.bus_req}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        set_nop();
        mem_wdata_i = 32'h0BAD_F00D; mem_wd_i = 5'd9; mem_wreg_i = 1'b1;
        #1;
        chk("rst_busy_stall", {31'h0, stall_req}, 32'h0);
        chk("rst_busy_wreg", {31'h0, wb_wreg}, 32'h0);
        @(posedge clk); #1;
        chk("rst_busy_req", {31'h0, mbus.bus_req}, 32'h0);
        rst = 1'b0;
        mbus.bus_ack = 1'b1; mbus.bus_rdata = 32'h5555_5555;
        @(posedge clk); #1;
        mbus.bus_ack = 1'b0; mbus.bus_rdata = 32'h0;
        chk("late_ack_req", {31'h0, mbus.bus_req}, 32'h0);
        chk("late_ack_stall", {31'h0, stall_req}, 32'h0);
        chk("late_ack_wdata", wb_wdata, 32'h0BAD_F00D);
        set_nop();
        @(posedge clk); #1;

        push_bus(32'h104, 4'b1111, 1'b0, 32'h0, 1'b0);
        push_resp(0, 32'h0102_0304, 1'b1);
        push_wb(32'h0102_0304, 1'b1, 5'd14, 1'b1, 1'b0, 1'b0, 2);
        run_op(OP_LW, 32'h104, 32'h0, 32'h104, 5'd14, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk("bus_q_left", bus_q.size(), 32'd0);
        chk("wb_q_left", wb_q.size(), 32'd0);
        chk("err_pulses", n_errp, 32'd1);
`ifdef MEM_ALIGN_CHECK_EN
        chk("bus_requests", n_req, 32'd10);
`else
        chk("bus_requests", n_req, 32'd12);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage consumer of the EX/MEM pipeline register. It takes the op, address, store data and writeback info, and performs loads and stores on a req/ack data bus.
- Stalls the pipeline until the bus transfer completes, then presents the writeback triple to the MEM/WB register.
- Byte-lane steering is big-endian; loads are sign- or zero-extended.
- Non-memory ops pass through combinationally with zero added latency.

Parameters:
- TIMEOUT_CYCLES, 255: maximum BUSY cycles spent waiting for bus_ack before the access is aborted. A value of 0 disables the timeout.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst  in  1  synchronous, active-high reset.
- mem_wdata_i  in  32  ALU result / writeback data from EX/MEM.
- mem_wd_i  in  5  destination register.
- mem_wreg_i  in  1  write enable.
- mem_aluop_i  in  8  operation code (OP_* from shared header).
- mem_mem_addr_i  in  32  effective address.
- mem_reg2_i  in  32  store data.
- stall_req  out  1  holds PC, IF/ID, ID/EX and EX/MEM.
- bus_req  out  1  registered request.
- bus_we  out  1  1 = store.
- bus_addr  out  32  word address, bits [1:0] always 00.
- bus_sel  out  4  byte enables; bit3 = bits[31:24].
- bus_wdata  out  32  store data, replicated into lanes.
- bus_rdata  in  32  load data, valid with bus_ack.
- bus_ack  in  1  one-cycle completion strobe.
- bus_err  out  1  one-cycle pulse on timeout.
- wb_wdata  out  32  to MEM/WB.
- wb_wd  out  5  to MEM/WB.
- wb_wreg  out  1  to MEM/WB.
- align_exc  out  1  see Optional Feature.

Behaviour:
- Memory ops: OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW. All other ops are pass-through: wb_* = mem_*_i and stall_req = 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE with a memory op:
  - stall_req = 1 (combinational).
  - On the next edge, register bus_addr = {addr[31:2],2'b00}, bus_sel, bus_wdata and bus_we; set bus_req = 1; clear the timeout counter; go to BUSY.
- BUSY:
  - stall_req = 1; the counter increments each cycle.
  - bus_ack = 1: capture bus_rdata into rdata_q, drop bus_req, go to DONE. Ack may arrive in the first BUSY cycle.
  - Counter reaches TIMEOUT_CYCLES (when nonzero) without ack: drop bus_req, pulse bus_err, set rdata_q = 0, go to DONE.
- DONE:
  - stall_req = 0. For a load, wb_wdata = extended rdata_q; for a store, wb_wreg = 0. Go to IDLE.
  - The pipeline advances at this edge. The next op is sampled in IDLE on the following cycle.
- Latency: a memory op occupies 3 + k cycles, where k = BUSY cycles before ack.
- While stall_req = 1: wb_wreg = 0 and wb_wd = 0, so MEM/WB receives a bubble.
- Store lanes:
  - SB: sel = 4'b1000 >> addr[1:0]; wdata = {4{reg2[7:0]}}.
  - SH: sel = addr[1] ? 0011 : 1100; wdata = {2{reg2[15:0]}}.
  - SW: sel = 1111.
- Load extract: addr[1:0] = 00 selects rdata[31:24]; halfword addr[1] = 0 selects [31:16]. LB/LH sign-extend; LBU/LHU zero-extend.
- Misaligned access without the feature: the low address bits beyond the access size are ignored (addr[0] for SH/LH/LHU; addr[1:0] for SW/LW).
- bus_ack in IDLE or DONE is ignored.
- Reset (any state, including mid-BUSY):
  - State = IDLE; bus_req, bus_we, bus_sel, bus_addr, bus_wdata, rdata_q, counter and bus_err = 0.
  - stall_req = 0 and wb_* = 0 while rst = 1.
  - A late ack after reset is ignored.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - A halfword op with addr[0] = 1, or a word op with addr[1:0] != 00, starts no bus access.
  - align_exc = 1 combinationally for that cycle; wb_wreg = 0; stall_req = 0.
- Undefined: align_exc is tied to 0 and misaligned accesses are truncated as above.

Decomposition:
- Shared header (header.v): OP_* load/store codes, zeroWord, NOP_REG_ADDR, and state encodings for IDLE/BUSY/DONE.
- Sub-module mem_lane_align: combinational; computes bus_sel/bus_wdata from (aluop, addr[1:0], reg2) and extended load data from (aluop, addr[1:0], rdata_q). The FSM, counter and registers stay in the top.

Test Plan:
- OP_SW, addr 0x100, reg2 0xDEADBEEF, ack after 2 cycles -> bus_addr = 0x100, sel = 1111, we = 1; stall high for 4 cycles; wb_wreg = 0.
- OP_LB, addr 0x203, rdata 0x1122_33F0, ack immediate -> sel = 0001; wb_wdata = 0xFFFF_FFF0, wb_wreg = 1 in DONE; 3 cycles total.
- OP_LHU, addr 0x202, rdata 0xAAAA_8001 -> wb_wdata = 0x0000_8001; OP_LH on the same data -> 0xFFFF_8001.
- Assert rst during BUSY, then ack one cycle later -> bus_req = 0 after the edge, state IDLE, ack ignored, no writeback.
- TIMEOUT_CYCLES = 4, never ack on OP_LW -> bus_err pulses once after 4 BUSY cycles; wb_wdata = 0; stall released the next cycle.
- MEM_ALIGN_CHECK_EN defined, OP_LW at 0x102 -> align_exc = 1, bus_req stays 0, stall_req = 0, wb_wreg = 0.
